sgmii_rx_pkt_gate: RTL and testbench

- Sits directly downstream of the SGMII receive converter. Drains its two FIFOs: the 134-bit packet FIFO and the 1-bit per-packet valid FIFO.
- Packets whose valid bit is 1 are forwarded into the pipeline input FIFO. Errored packets are discarded word-by-word.
- Guards the pipeline against malformed framing (missing head) and runaway packets (missing tail), and produces statistics pulses.

---
 rtl/sgmii_rx_pkt_gate.sv | 133 +++++++++++++
 tb/tb_sgmii_rx_pkt_gate.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sgmii_rx_pkt_gate.sv
// sgmii_rx_pkt_gate
// Drains the SGMII receive converter's packet FIFO and per-packet valid FIFO.
// Good packets are forwarded to the pipeline FIFO with one cycle of latency.
// Errored packets are discarded word by word. Packets with a bad head are
// dropped, and packets that run past MAX_PKT_WORDS are truncated with a
// forced tail. Each packet produces exactly one single-cycle statistics pulse.
module sgmii_rx_pkt_gate #(
    parameter int unsigned MAX_PKT_WORDS = 96,
    parameter int unsigned CNT_W         = 7
) (
    input  logic         clk,
    input  logic         reset,

    output logic         in_pkt_rdreq,
    input  logic [133:0] in_pkt,
    input  logic         in_pkt_empty,

    output logic         in_valid_rdreq,
    input  logic         in_valid,
    input  logic         in_valid_empty,

    output logic         out_pkt_wrreq,
    output logic [133:0] out_pkt,
    input  logic         out_pkt_almostfull,

    output logic         pkt_forward_add,
    output logic         pkt_errdrop_add,
    output logic         pkt_malform_add
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FWD,
        ST_DROP
    } state_t;

    localparam logic [CNT_W-1:0] LP_MAX  = CNT_W'(MAX_PKT_WORDS);
    localparam logic [1:0]       HDR_HEAD = 2'b01;
    localparam logic [1:0]       HDR_TAIL = 2'b10;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    logic             w_idle_ready;
    logic             w_valid_pop;
    logic             w_pkt_pop;
    logic [1:0]       w_hdr;
    logic             w_is_tail;
    logic             w_first;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_at_max;

    // Pop decisions are combinational: the FIFOs are show-ahead, so the pop
    // must coincide with the cycle in which the head word is consumed.
    always_comb begin
        w_idle_ready = (r_state == ST_IDLE) && !in_valid_empty && !in_pkt_empty;
        w_valid_pop  = w_idle_ready && (!in_valid || !out_pkt_almostfull);
        w_pkt_pop    = (r_state != ST_IDLE) && !in_pkt_empty;
        w_hdr        = in_pkt[133:132];
        w_is_tail    = (w_hdr == HDR_TAIL);
        w_first      = (r_cnt == '0);
        w_cnt_inc    = (r_cnt == LP_MAX) ? r_cnt : r_cnt + 1'b1;
        w_at_max     = (w_cnt_inc == LP_MAX);
    end

    // Read strobes are held low while reset is asserted so every output is 0.
    assign in_valid_rdreq = w_valid_pop && !reset;
    assign in_pkt_rdreq   = w_pkt_pop && !reset;

    // Packet FSM with registered write path and statistics pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_cnt           <= '0;
            out_pkt_wrreq   <= 1'b0;
            out_pkt         <= '0;
            pkt_forward_add <= 1'b0;
            pkt_errdrop_add <= 1'b0;
            pkt_malform_add <= 1'b0;
        end else begin
            out_pkt_wrreq   <= 1'b0;
            pkt_forward_add <= 1'b0;
            pkt_errdrop_add <= 1'b0;
            pkt_malform_add <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_idle_ready) begin
                        if (!in_valid) begin
                            pkt_errdrop_add <= 1'b1;
                            r_state         <= ST_DROP;
                        end else if (!out_pkt_almostfull) begin
                            r_cnt   <= '0;
                            r_state <= ST_FWD;
                        end
                    end
                end
                ST_FWD: begin
                    if (!in_pkt_empty) begin
                        r_cnt <= w_cnt_inc;
                        if (w_first && (w_hdr != HDR_HEAD)) begin
                            pkt_malform_add <= 1'b1;
                            r_state         <= w_is_tail ? ST_IDLE : ST_DROP;
                        end else if (w_is_tail) begin
                            out_pkt_wrreq   <= 1'b1;
                            out_pkt         <= in_pkt;
                            pkt_forward_add <= 1'b1;
                            r_state         <= ST_IDLE;
                        end else if (w_at_max) begin
                            // Truncate: close the packet downstream with an
                            // all-bytes-valid tail and discard the remainder.
                            out_pkt_wrreq   <= 1'b1;
                            out_pkt         <= {HDR_TAIL, 4'b0000, in_pkt[127:0]};
                            pkt_malform_add <= 1'b1;
                            r_state         <= ST_DROP;
                        end else begin
                            out_pkt_wrreq <= 1'b1;
                            out_pkt       <= in_pkt;
                        end
                    end
                end
                ST_DROP: begin
                    if (!in_pkt_empty && w_is_tail) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sgmii_rx_pkt_gate.sv
// Bench for sgmii_rx_pkt_gate: show-ahead FIFO models feed the DUT, expected
// output words are queued when a packet is enqueued and popped on each write.
module tb_sgmii_rx_pkt_gate;

    localparam int unsigned MAXW = 96;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_pkt_rdreq;
    logic [133:0] in_pkt;
    logic         in_pkt_empty;
    logic         in_valid_rdreq;
    logic         in_valid;
    logic         in_valid_empty;
    logic         out_pkt_wrreq;
    logic [133:0] out_pkt;
    logic         out_pkt_almostfull;
    logic         pkt_forward_add;
    logic         pkt_errdrop_add;
    logic         pkt_malform_add;

    always #5 clk = ~clk;

    sgmii_rx_pkt_gate #(
        .MAX_PKT_WORDS(MAXW),
        .CNT_W(7)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_pkt_rdreq(in_pkt_rdreq),
        .in_pkt(in_pkt),
        .in_pkt_empty(in_pkt_empty),
        .in_valid_rdreq(in_valid_rdreq),
        .in_valid(in_valid),
        .in_valid_empty(in_valid_empty),
        .out_pkt_wrreq(out_pkt_wrreq),
        .out_pkt(out_pkt),
        .out_pkt_almostfull(out_pkt_almostfull),
        .pkt_forward_add(pkt_forward_add),
        .pkt_errdrop_add(pkt_errdrop_add),
        .pkt_malform_add(pkt_malform_add)
    );

    logic [133:0] pkt_q[$];
    logic         val_q[$];
    logic [133:0] exp_q[$];

    int n_vec = 0;
    int n_err = 0;
    int exp_fwd = 0, exp_drp = 0, exp_mal = 0;
    int got_fwd = 0, got_drp = 0, got_mal = 0;
    logic gap_mode  = 1'b0;
    logic gap_phase = 1'b0;
    logic last_pr   = 1'b0;
    logic last_vr   = 1'b0;

    task automatic check(input string tag, input logic [133:0] obs, input logic [133:0] expv);
        n_vec++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic drive_inputs();
        in_pkt         = (pkt_q.size() != 0) ? pkt_q[0] : '0;
        in_pkt_empty   = (pkt_q.size() == 0) || (gap_mode && gap_phase);
        in_valid       = (val_q.size() != 0) ? val_q[0] : 1'b0;
        in_valid_empty = (val_q.size() == 0);
    endtask

    // Enqueue one packet and derive its expected output words and statistic.
    task automatic send_pkt(input int nwords, input logic valid, input logic [1:0] first_hdr,
                            input logic [3:0] tail_mod);
        logic [133:0] w[$];
        logic [1:0]   h;
        logic [3:0]   m;
        for (int i = 0; i < nwords; i++) begin
            h = (i == 0) ? first_hdr : ((i == nwords - 1) ? 2'b10 : 2'b11);
            m = (h == 2'b10) ? tail_mod : 4'h0;
            w.push_back({h, m, $urandom(), $urandom(), $urandom(), $urandom()});
        end
        foreach (w[i]) pkt_q.push_back(w[i]);
        val_q.push_back(valid);
        if (!valid) begin
            exp_drp++;
        end else if (first_hdr != 2'b01) begin
            exp_mal++;
        end else begin
            for (int i = 0; i < nwords; i++) begin
                if (w[i][133:132] == 2'b10) begin
                    exp_q.push_back(w[i]);
                    exp_fwd++;
                    break;
                end
                if (i + 1 == int'(MAXW)) begin
                    exp_q.push_back({2'b10, 4'h0, w[i][127:0]});
                    exp_mal++;
                    break;
                end
                exp_q.push_back(w[i]);
            end
        end
        drive_inputs();
    endtask

    // One clock: sample pops before the edge, apply them after, check outputs.
    task automatic tick();
        logic pr, vr;
        logic [133:0] e;
        @(negedge clk);
        pr = in_pkt_rdreq;
        vr = in_valid_rdreq;
        if (pr) check("pkt_rdreq_while_empty", in_pkt_empty, 1'b0);
        if (vr) check("valid_rdreq_while_empty", in_valid_empty, 1'b0);
        @(posedge clk);
        #1;
        if (pr && pkt_q.size() != 0) void'(pkt_q.pop_front());
        if (vr && val_q.size() != 0) void'(val_q.pop_front());
        gap_phase = ~gap_phase;
        drive_inputs();
        last_pr = pr;
        last_vr = vr;
        if (out_pkt_wrreq) begin
            check("write_latency_rdreq", pr, 1'b1);
            if (exp_q.size() == 0) begin
                check("unexpected_write", out_pkt_wrreq, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("out_pkt", out_pkt, e);
            end
        end
        check("stat_exclusive", 134'($countones({pkt_forward_add, pkt_errdrop_add, pkt_malform_add}) <= 1), 134'(1));
        got_fwd += int'(pkt_forward_add);
        got_drp += int'(pkt_errdrop_add);
        got_mal += int'(pkt_malform_add);
    endtask

    task automatic run_until_done(input string tag, input int budget);
        int k;
        k = 0;
        while ((pkt_q.size() != 0 || val_q.size() != 0 || exp_q.size() != 0) && k < budget) begin
            tick();
            k++;
        end
        n_vec++;
        assert (k < budget)
        else begin
            n_err++;
            $error("FAIL %s_timeout observed=%0d expected<%0d", tag, k, budget);
        end
        repeat (2) tick();
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_fwd_cnt"}, 134'(got_fwd), 134'(exp_fwd));
        check({tag, "_errdrop_cnt"}, 134'(got_drp), 134'(exp_drp));
        check({tag, "_malform_cnt"}, 134'(got_mal), 134'(exp_mal));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_out_pkt"}, out_pkt, '0);
        check({tag, "_wrreq"}, out_pkt_wrreq, 1'b0);
        check({tag, "_pkt_rdreq"}, in_pkt_rdreq, 1'b0);
        check({tag, "_valid_rdreq"}, in_valid_rdreq, 1'b0);
        check({tag, "_fwd"}, pkt_forward_add, 1'b0);
        check({tag, "_errdrop"}, pkt_errdrop_add, 1'b0);
        check({tag, "_malform"}, pkt_malform_add, 1'b0);
    endtask

    initial begin
        int   rd_seen;
        int   k;
        logic started;

        reset              = 1'b1;
        out_pkt_almostfull = 1'b0;
        drive_inputs();
        #1;
        check_outputs_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) tick();

        // Good 3-word packet with partial tail.
        send_pkt(3, 1'b1, 2'b01, 4'hC);
        run_until_done("good3", 40);
        check_stats("good3");

        // Errored 4-word packet then a good head+tail packet.
        send_pkt(4, 1'b0, 2'b01, 4'h3);
        send_pkt(2, 1'b1, 2'b01, 4'h5);
        run_until_done("errdrop", 60);
        check_stats("errdrop");
        check("valid_fifo_drained", 134'(val_q.size()), 134'(0));

        // Almost-full holds admission; release; re-assert mid-packet.
        out_pkt_almostfull = 1'b1;
        send_pkt(8, 1'b1, 2'b01, 4'h1);
        rd_seen = 0;
        repeat (10) begin
            tick();
            if (last_pr || last_vr) rd_seen++;
        end
        check("af_hold_no_rdreq", 134'(rd_seen), 134'(0));
        out_pkt_almostfull = 1'b0;
        started = 1'b0;
        k = 0;
        while (!started && k < 2) begin
            tick();
            k++;
            if (last_pr) started = 1'b1;
        end
        check("af_release_start", started, 1'b1);
        tick();
        out_pkt_almostfull = 1'b1;
        run_until_done("af_mid", 60);
        out_pkt_almostfull = 1'b0;
        check_stats("af");

        // Runaway packet truncated at MAX_PKT_WORDS, then a normal packet.
        send_pkt(100, 1'b1, 2'b01, 4'h7);
        send_pkt(3, 1'b1, 2'b01, 4'h2);
        run_until_done("overlen", 300);
        check_stats("overlen");

        // Bad head (middle), bad head that is a tail, then a good packet.
        send_pkt(4, 1'b1, 2'b11, 4'h9);
        send_pkt(1, 1'b1, 2'b10, 4'h4);
        send_pkt(2, 1'b1, 2'b01, 4'hE);
        run_until_done("badhead", 60);
        check_stats("badhead");

        // Packet FIFO intermittently empty during forwarding.
        gap_mode = 1'b1;
        send_pkt(6, 1'b1, 2'b01, 4'hA);
        run_until_done("gaps", 80);
        gap_mode = 1'b0;
        drive_inputs();
        check_stats("gaps");

        // Asynchronous reset in the middle of a forwarded packet.
        send_pkt(10, 1'b1, 2'b01, 4'hB);
        repeat (5) tick();
        #2;
        reset = 1'b1;
        #1;
        check_outputs_zero("midreset");
        exp_fwd--;
        pkt_q.delete();
        val_q.delete();
        exp_q.delete();
        drive_inputs();
        repeat (2) tick();
        reset = 1'b0;
        tick();
        send_pkt(3, 1'b1, 2'b01, 4'h6);
        run_until_done("postreset", 40);
        check_stats("postreset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
